// File: rtl/uart_controller.sv
// 8N1 UART peripheral: 2-flop synchronized receiver and a transmitter sharing a
// BIT_TICKS = clk_freq/baudrate timebase. Optional macro UART_RX_FRAME_CHECK_EN drops frames whose stop bit is low.
module uart_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int UART_Nbit  = 8,
    parameter int baudrate   = 5,
    parameter int clk_freq   = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SerialDataIn,
    input  logic                  clr_rx_flag,
    input  logic                  clr_tx_flag,
    input  logic [DATA_WIDTH-1:0] uart_tx,
    input  logic                  Start_Tx,
    input  logic                  enable_StoreTxbuff,
    output logic [DATA_WIDTH-1:0] UART_data,
    output logic                  SerialDataOut,
    output logic [DATA_WIDTH-1:0] Rx_flag_out,
    output logic [DATA_WIDTH-1:0] Tx_flag_out
);
    localparam int BIT_TICKS = clk_freq / baudrate;
    localparam int CW = $clog2(BIT_TICKS);
    localparam int BW = (UART_Nbit > 1) ? $clog2(UART_Nbit) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_TICKS / 2 - 1);
    localparam logic [BW-1:0] BIT_ZERO = BW'(0);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_Nbit - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic                 sync1_r, sync2_r, rx_prev_r;
    state_t               rx_state_r, rx_next_s;
    logic [CW-1:0]        rx_cnt_r, rx_cnt_s;
    logic [BW-1:0]        rx_bit_r, rx_bit_s;
    logic [UART_Nbit-1:0] rx_shift_r, rx_shift_s, rx_data_r;
    logic                 rx_done_s, rx_flag_r;

    logic                 start_prev_r, start_edge_s;
    logic [UART_Nbit-1:0] tx_buf_r, tx_shift_r, tx_shift_s;
    state_t               tx_state_r, tx_next_s;
    logic [CW-1:0]        tx_cnt_r, tx_cnt_s;
    logic [BW-1:0]        tx_bit_r, tx_bit_s;
    logic                 tx_line_r, tx_line_s, tx_done_s, tx_flag_r;

    logic unused_s;
    assign unused_s = ^uart_tx[DATA_WIDTH-1:UART_Nbit];

    // RX line synchronizer and previous-value register for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= SerialDataIn;
            sync2_r   <= sync1_r;
            rx_prev_r <= sync2_r;
        end
    end

    // RX FSM state, bit timer, bit index and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= BIT_ZERO;
            rx_shift_r <= {UART_Nbit{1'b0}};
        end else begin
            rx_state_r <= rx_next_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
        end
    end

    // RX next-state: half-bit start check, then mid-bit sampling of data and stop
    always_comb begin
        rx_next_s  = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_done_s  = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                rx_cnt_s = CNT_ZERO;
                rx_bit_s = BIT_ZERO;
                // A line still low after a framing error cannot produce this edge
                if (rx_prev_r && !sync2_r) begin
                    rx_next_s = ST_START;
                end else begin
                    rx_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == CNT_HALF) begin
                    rx_cnt_s = CNT_ZERO;
                    if (sync2_r) begin
                        rx_next_s = ST_IDLE;
                    end else begin
                        rx_next_s = ST_DATA;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s   = CNT_ZERO;
                    rx_shift_s = {sync2_r, rx_shift_r[UART_Nbit-1:1]};
                    if (rx_bit_r == BIT_LAST) begin
                        rx_next_s = ST_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + BIT_ONE;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s  = CNT_ZERO;
                    rx_next_s = ST_IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
                    rx_done_s = sync2_r;
`else
                    rx_done_s = 1'b1;
`endif
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_next_s = ST_IDLE;
                rx_cnt_s  = CNT_ZERO;
                rx_bit_s  = BIT_ZERO;
            end
        endcase
    end

    // Received byte and sticky RX flag; set wins over clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_r <= {UART_Nbit{1'b0}};
            rx_flag_r <= 1'b0;
        end else begin
            if (rx_done_s) begin
                rx_data_r <= rx_shift_r;
            end
            if (rx_done_s) begin
                rx_flag_r <= 1'b1;
            end else if (!clr_rx_flag) begin
                rx_flag_r <= 1'b0;
            end
        end
    end

    assign start_edge_s = Start_Tx & ~start_prev_r;

    // TX buffer, start edge detector, FSM registers, registered line and TX flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_prev_r <= 1'b0;
            tx_buf_r     <= {UART_Nbit{1'b0}};
            tx_state_r   <= ST_IDLE;
            tx_cnt_r     <= CNT_ZERO;
            tx_bit_r     <= BIT_ZERO;
            tx_shift_r   <= {UART_Nbit{1'b0}};
            tx_line_r    <= 1'b1;
            tx_flag_r    <= 1'b0;
        end else begin
            start_prev_r <= Start_Tx;
            if (enable_StoreTxbuff) begin
                tx_buf_r <= uart_tx[UART_Nbit-1:0];
            end
            tx_state_r <= tx_next_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_line_r  <= tx_line_s;
            if (tx_done_s) begin
                tx_flag_r <= 1'b1;
            end else if (!clr_tx_flag) begin
                tx_flag_r <= 1'b0;
            end
        end
    end

    // TX next-state: the line value for the next bit period is computed one clock ahead
    always_comb begin
        tx_next_s  = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_line_s  = tx_line_r;
        tx_done_s  = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                tx_cnt_s = CNT_ZERO;
                tx_bit_s = BIT_ZERO;
                if (start_edge_s) begin
                    tx_shift_s = tx_buf_r;
                    tx_next_s  = ST_START;
                    tx_line_s  = 1'b0;
                end else begin
                    tx_next_s  = ST_IDLE;
                    tx_line_s  = 1'b1;
                end
            end
            ST_START: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s  = CNT_ZERO;
                    tx_next_s = ST_DATA;
                    tx_line_s = tx_shift_r[0];
                end else begin
                    tx_cnt_s  = tx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s = CNT_ZERO;
                    if (tx_bit_r == BIT_LAST) begin
                        tx_next_s = ST_STOP;
                        tx_line_s = 1'b1;
                    end else begin
                        tx_bit_s   = tx_bit_r + BIT_ONE;
                        tx_shift_s = {1'b0, tx_shift_r[UART_Nbit-1:1]};
                        tx_line_s  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s  = CNT_ZERO;
                    tx_next_s = ST_IDLE;
                    tx_line_s = 1'b1;
                    tx_done_s = 1'b1;
                end else begin
                    tx_cnt_s  = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_next_s = ST_IDLE;
                tx_cnt_s  = CNT_ZERO;
                tx_bit_s  = BIT_ZERO;
                tx_line_s = 1'b1;
            end
        endcase
    end

    assign UART_data     = {{(DATA_WIDTH-UART_Nbit){1'b0}}, rx_data_r};
    assign SerialDataOut = tx_line_r;
    assign Rx_flag_out   = {{(DATA_WIDTH-1){1'b0}}, rx_flag_r};
    assign Tx_flag_out   = {{(DATA_WIDTH-1){1'b0}}, tx_flag_r};

endmodule

// File: tb/tb_uart_controller.sv
// Scoreboard bench for uart_controller: directed stimulus pushes expected bytes,
// independent RX/TX monitors pop and compare when the DUT reports a byte or emits a frame.
module tb_uart_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic        SerialDataIn;
    logic        clr_rx_flag;
    logic        clr_tx_flag;
    logic [31:0] uart_tx;
    logic        Start_Tx;
    logic        enable_StoreTxbuff;
    logic [31:0] UART_data;
    logic        SerialDataOut;
    logic [31:0] Rx_flag_out;
    logic [31:0] Tx_flag_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    uart_controller dut (
        .clk(clk), .reset(reset), .SerialDataIn(SerialDataIn),
        .clr_rx_flag(clr_rx_flag), .clr_tx_flag(clr_tx_flag),
        .uart_tx(uart_tx), .Start_Tx(Start_Tx), .enable_StoreTxbuff(enable_StoreTxbuff),
        .UART_data(UART_data), .SerialDataOut(SerialDataOut),
        .Rx_flag_out(Rx_flag_out), .Tx_flag_out(Tx_flag_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        SerialDataIn = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            SerialDataIn = b[i];
            tick(10);
        end
        SerialDataIn = stop_bit;
        tick(10);
        SerialDataIn = 1'b1;
    endtask

    task automatic wait_tx_flag(input string name, input int max);
        int n;
        n = 0;
        while (Tx_flag_out[0] !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (Tx_flag_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s: tx flag not set within %0d clocks", name, max);
        end
        tick(1);
    endtask

    task automatic clear_tx;
        clr_tx_flag = 1'b0;
        tick(1);
        clr_tx_flag = 1'b1;
    endtask

    task automatic clear_rx;
        clr_rx_flag = 1'b0;
        tick(1);
        clr_rx_flag = 1'b1;
    endtask

    // RX monitor: every rising RX flag must match the next expected byte
    initial begin
        logic pf;
        logic [7:0] e;
        pf = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && Rx_flag_out[0] === 1'b1 && pf === 1'b0) begin
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got byte %h expected none", UART_data);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_data", UART_data, {24'h0, e});
                end
            end
            pf = Rx_flag_out[0];
        end
    end

    // TX monitor: samples each frame mid-bit, checks content and flag timing
    initial begin
        logic       prev_line;
        logic [9:0] s;
        logic [7:0] e;
        int         t0;
        int         n;
        bit         abort;
        prev_line = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && prev_line === 1'b1 && SerialDataOut === 1'b0) begin
                t0 = cyc;
                abort = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    for (int k = 0; k < ((i == 0) ? 4 : 10); k++) begin
                        @(negedge clk);
                        if (reset) abort = 1'b1;
                    end
                    s[i] = SerialDataOut;
                end
                if (!abort) begin
                    n = 0;
                    while (Tx_flag_out[0] !== 1'b1 && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    check("tx_flag_time", cyc - t0, 32'd100);
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got frame %h expected none", s);
                    end else begin
                        e = tx_q.pop_front();
                        check("tx_frame", {22'h0, s}, {22'h0, 1'b1, e, 1'b0});
                    end
                end
            end
            prev_line = SerialDataOut;
        end
    end

    initial begin
        reset = 1'b1;
        SerialDataIn = 1'b1;
        clr_rx_flag = 1'b1;
        clr_tx_flag = 1'b1;
        uart_tx = 32'h0;
        Start_Tx = 1'b0;
        enable_StoreTxbuff = 1'b0;
        tick(3);
        check("reset_line", {31'h0, SerialDataOut}, 32'h1);
        check("reset_data", UART_data, 32'h0);
        check("reset_rxflag", Rx_flag_out, 32'h0);
        check("reset_txflag", Tx_flag_out, 32'h0);
        reset = 1'b0;
        tick(20);
        check("idle_line", {31'h0, SerialDataOut}, 32'h1);

        // Receive 0x39, then clear the flag
        rx_q.push_back(8'h39);
        send_rx(8'h39, 1'b1);
        check("rx39_flag", Rx_flag_out, 32'h1);
        check("rx39_data", UART_data, 32'h39);
        clear_rx();
        check("rx_clr_flag", Rx_flag_out, 32'h0);
        check("rx_clr_data", UART_data, 32'h39);

        // Transmit 0x78 from 0x12345678; buffer must hold after enable drops
        uart_tx = 32'h12345678;
        enable_StoreTxbuff = 1'b1;
        tick(1);
        enable_StoreTxbuff = 1'b0;
        uart_tx = 32'hFFFFFFFF;
        tx_q.push_back(8'h78);
        Start_Tx = 1'b1;
        tick(1);
        Start_Tx = 1'b0;
        wait_tx_flag("tx78_done", 150);
        check("tx78_flag", Tx_flag_out, 32'h1);
        clear_tx();
        check("tx_clr_flag", Tx_flag_out, 32'h0);

        // Second pulse mid-frame is ignored
        tx_q.push_back(8'h78);
        Start_Tx = 1'b1;
        tick(1);
        Start_Tx = 1'b0;
        tick(35);
        Start_Tx = 1'b1;
        tick(1);
        Start_Tx = 1'b0;
        wait_tx_flag("tx_mid_done", 150);
        clear_tx();
        tick(150);
        check("tx_no_retrigger", Tx_flag_out, 32'h0);

        // Level held high retransmits once only
        tx_q.push_back(8'h78);
        Start_Tx = 1'b1;
        wait_tx_flag("tx_level_done", 150);
        clear_tx();
        tick(150);
        check("tx_level_once", Tx_flag_out, 32'h0);
        Start_Tx = 1'b0;
        tick(2);

        // 3-clock glitch is rejected
        SerialDataIn = 1'b0;
        tick(3);
        SerialDataIn = 1'b1;
        tick(150);
        check("glitch_flag", Rx_flag_out, 32'h0);
        check("glitch_data", UART_data, 32'h39);

        // Set wins over a clear held across completion
        clr_rx_flag = 1'b0;
        rx_q.push_back(8'hA5);
        send_rx(8'hA5, 1'b1);
        tick(5);
        clr_rx_flag = 1'b1;
        check("simul_cleared", Rx_flag_out, 32'h0);
        check("simul_data", UART_data, 32'hA5);

        // Frame with a low stop bit
`ifndef UART_RX_FRAME_CHECK_EN
        rx_q.push_back(8'h5A);
`endif
        send_rx(8'h5A, 1'b0);
        tick(20);
`ifdef UART_RX_FRAME_CHECK_EN
        check("frame_err_flag", Rx_flag_out, 32'h0);
        check("frame_err_data", UART_data, 32'hA5);
`else
        check("badstop_flag", Rx_flag_out, 32'h1);
        check("badstop_data", UART_data, 32'h5A);
        clear_rx();
`endif
        rx_q.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        check("rearm_data", UART_data, 32'h3C);
        clear_rx();

        // RX and TX concurrently
        uart_tx = 32'h00000096;
        enable_StoreTxbuff = 1'b1;
        tick(1);
        enable_StoreTxbuff = 1'b0;
        tx_q.push_back(8'h96);
        rx_q.push_back(8'h0F);
        fork
            send_rx(8'h0F, 1'b1);
            begin
                Start_Tx = 1'b1;
                tick(1);
                Start_Tx = 1'b0;
            end
        join
        wait_tx_flag("conc_tx_done", 150);
        check("conc_rx_data", UART_data, 32'h0F);
        check("conc_rx_flag", Rx_flag_out, 32'h1);
        clear_tx();
        clear_rx();

        // Reset mid-frame aborts the frame; buffer is cleared
        Start_Tx = 1'b1;
        tick(1);
        Start_Tx = 1'b0;
        tick(30);
        reset = 1'b1;
        tick(1);
        check("abort_line", {31'h0, SerialDataOut}, 32'h1);
        reset = 1'b0;
        tick(120);
        check("abort_txflag", Tx_flag_out, 32'h0);
        check("abort_idle", {31'h0, SerialDataOut}, 32'h1);
        tx_q.push_back(8'h00);
        Start_Tx = 1'b1;
        tick(1);
        Start_Tx = 1'b0;
        wait_tx_flag("tx_zero_done", 150);

        tick(50);
        check("rx_q_empty", rx_q.size(), 32'd0);
        check("tx_q_empty", tx_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_controller.md
Name: uart_controller

Overview:
- Memory-mapped-style UART peripheral for the MIPS SoC: one 8N1 receiver and one 8N1 transmitter sharing a common baud timebase derived from parameters.
- Exposes the received byte, RX/TX status flags and the TX buffer as DATA_WIDTH-wide words so the processor bus can read and write them directly.
- Flags are sticky and are cleared by active-low clear strobes from software.

Parameters:
- DATA_WIDTH, 32, width of the bus-facing data/flag words.
- UART_Nbit, 8, data bits per frame (LSB first).
- baudrate, 5, baud rate in the same unit as clk_freq.
- clk_freq, 50, clock frequency; BIT_TICKS = clk_freq/baudrate clocks per bit (default 10); requires BIT_TICKS ≥ 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- SerialDataIn  input  1  RX serial line, idle high.
- clr_rx_flag  input  1  active-low; 0 clears the RX flag.
- clr_tx_flag  input  1  active-low; 0 clears the TX flag.
- uart_tx  input  DATA_WIDTH  word to transmit; bits [UART_Nbit-1:0] are used.
- Start_Tx  input  1  rising edge starts a transmission.
- enable_StoreTxbuff  input  1  level; while 1, TX buffer loads uart_tx each clock.
- UART_data  output  DATA_WIDTH  last received byte, zero-extended.
- SerialDataOut  output  1  TX serial line, idle high.
- Rx_flag_out  output  DATA_WIDTH  bit0 = RX flag, upper bits 0.
- Tx_flag_out  output  DATA_WIDTH  bit0 = TX-done flag, upper bits 0.

Behaviour:
- Reset (async, active-high) clears all state:
  - SerialDataOut=1; UART_data=0; both flags=0; TX buffer=0.
  - RX and TX FSMs return to IDLE.
- Frame format: 1 start bit (0), UART_Nbit data bits LSB first, 1 stop bit (1). No parity.
- RX input handling:
  - SerialDataIn passes through a 2-flop synchronizer.
  - The RX FSM acts on the synchronized signal only.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized 1->0 transition.
  - START: wait BIT_TICKS/2 clocks, then sample. If the sample is 1 (glitch), return to IDLE; otherwise go to DATA.
  - DATA: sample every BIT_TICKS clocks (mid-bit) and shift in LSB first, UART_Nbit samples.
  - STOP: wait BIT_TICKS and sample. Load UART_data with the byte, set the RX flag, go to IDLE.
- A new frame overwrites UART_data even if the RX flag is still set. No overrun indication.
- TX buffer: while enable_StoreTxbuff=1, the buffer captures uart_tx[UART_Nbit-1:0] on each clock.
- TX FSM states: IDLE, START, DATA, STOP.
  - Start_Tx is edge-detected (registered previous value).
  - A rising edge seen in IDLE latches the buffer into the shift register. The next clock drives SerialDataOut=0 for BIT_TICKS.
  - Then UART_Nbit data bits, BIT_TICKS each, LSB first.
  - Then the stop bit (1) for BIT_TICKS.
  - On stop-bit completion: set the TX flag, return to IDLE, SerialDataOut=1.
- Start_Tx edges while TX is not IDLE are ignored. A level held high does not retrigger.
- Flags:
  - Set has priority over clear when both occur in the same clock.
  - Clear takes effect on the clock edge where clr_* is sampled 0.
- RX and TX operate fully independently and concurrently.
- Asserting reset mid-frame aborts the frame immediately:
  - Line returns high.
  - No flag is set.

Optional Feature:
- Macro UART_RX_FRAME_CHECK_EN.
- Defined: a stop-bit sample of 0 is a framing error. The byte is discarded (UART_data unchanged, RX flag not set) and the FSM returns to IDLE. It then waits for the line to be high before re-arming on a falling edge.
- Undefined: the stop-bit value is ignored; the byte is always loaded and the flag set.

Test Plan:
- Reset, then idle: SerialDataOut=1, UART_data=0, Rx_flag_out=0, Tx_flag_out=0.
- RX byte 0x39 (defaults, 10 clocks/bit): drive start bit, then data bits 1,0,0,1,1,1,0,0, then stop bit 1.
  - UART_data=32'h00000039 and Rx_flag_out=1 within 2 bit times after the stop-bit start.
  - Pulse clr_rx_flag=0 for one clock -> Rx_flag_out=0 and UART_data stays 0x39.
- TX: uart_tx=32'h12345678 with enable_StoreTxbuff=1, then a Start_Tx pulse.
  - SerialDataOut emits 0, 0,0,0,1,1,1,1,0, 1, each bit 10 clocks.
  - Tx_flag_out=1 after 100 clocks. Pulse clr_tx_flag low -> Tx_flag_out=0.
- A second Start_Tx pulse issued mid-frame is ignored: the frame is unchanged and exactly one TX flag set occurs. After the frame, a new pulse retransmits 0x78.
- A 3-clock low glitch on SerialDataIn gives no RX flag and leaves UART_data unchanged.
- Simultaneous set and clear: clr_rx_flag held 0 across stop-bit completion -> Rx_flag_out=1 on the set cycle. With UART_RX_FRAME_CHECK_EN defined, a frame with stop bit 0 leaves the RX flag 0.
